pipe_stage_elastic: RTL

//  Parametrised inter-stage pipeline register for the MIPS32 pipeline (F2D/D2E/E2M/M2W slots).

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_data_reg.sv | 26 ++
 rtl/pipe_stage_elastic.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy states and stage modes.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   localparam int MODE_REG     = 0;
   localparam int MODE_ELASTIC = 1;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with async reset, synchronous clear (priority) and load enable.
module pipe_data_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 96,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= CLEAR_VAL;
      end else if (clear) begin
         q <= CLEAR_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Inter-stage pipeline register: legacy enable/clear register (MODE 0) or
// 2-entry skid stage with registered in_ready (MODE 1), plus a saturating stall counter.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 96,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
   parameter int                MODE      = 1,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              m_load;
   logic [DATA_W-1:0] m_d;
   logic [DATA_W-1:0] m_q;
   logic [CNT_W-1:0]  stall_q;

   pipe_data_reg #(
      .DATA_W   (DATA_W),
      .CLEAR_VAL(CLEAR_VAL)
   ) u_main (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(flush),
      .load (m_load),
      .d    (m_d),
      .q    (m_q)
   );

   assign out_data = m_q;

   generate
      if (MODE == MODE_ELASTIC) begin : g_elastic
         pipe_state_e       state_q;
         pipe_state_e       state_d;
         logic              in_ready_q;
         logic              out_valid_q;
         logic              in_fire;
         logic              out_fire;
         logic              s_load;
         logic              m_from_skid;
         logic [DATA_W-1:0] s_q;

         pipe_data_reg #(
            .DATA_W   (DATA_W),
            .CLEAR_VAL(CLEAR_VAL)
         ) u_skid (
            .clk  (clk),
            .rst_n(rst_n),
            .clear(flush),
            .load (s_load),
            .d    (in_data),
            .q    (s_q)
         );

         assign in_fire  = in_valid & in_ready_q;
         assign out_fire = out_valid_q & out_ready;

         always_comb begin
            state_d     = state_q;
            m_load      = 1'b0;
            s_load      = 1'b0;
            m_from_skid = 1'b0;
            case (state_q)
               ST_EMPTY: begin
                  if (in_fire) begin
                     state_d = ST_ONE;
                     m_load  = 1'b1;
                  end
               end
               ST_ONE: begin
                  if (in_fire && out_fire) begin
                     m_load = 1'b1;
                  end else if (in_fire) begin
                     state_d = ST_FULL;
                     s_load  = 1'b1;
                  end else if (out_fire) begin
                     state_d = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  if (out_fire) begin
                     state_d     = ST_ONE;
                     m_load      = 1'b1;
                     m_from_skid = 1'b1;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
            // Data registers give clear priority over load, so only the state needs squashing here.
            if (flush) begin
               state_d = ST_EMPTY;
            end
         end

         assign m_d = m_from_skid ? s_q : in_data;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q     <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end else begin
               state_q     <= state_d;
               in_ready_q  <= (state_d != ST_FULL);
               out_valid_q <= (state_d != ST_EMPTY);
            end
         end

         assign in_ready  = in_ready_q;
         assign out_valid = out_valid_q;

         a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
            (in_valid && !in_ready_q && !flush) |=> (in_valid && $stable(in_data)));
      end else begin : g_reg
         logic valid_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_q <= 1'b0;
            end else if (flush) begin
               valid_q <= 1'b0;
            end else if (out_ready) begin
               valid_q <= in_valid;
            end
         end

         assign m_load    = out_ready;
         assign m_d       = in_data;
         assign in_ready  = out_ready;
         assign out_valid = valid_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;

endmodule
